// File: rtl/axil_regbank_pkg.sv
// Shared definitions for the AXI4-Lite register bank.
// AXIL_REGBANK_SLVERR_EN selects SLVERR (instead of OKAY) for out-of-range accesses.
package axil_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXIL_REGBANK_SLVERR_EN
  localparam logic [1:0] RESP_OOR = RESP_SLVERR;
`else
  localparam logic [1:0] RESP_OOR = RESP_OKAY;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HAVE_AW = 2'd1,
    HAVE_W  = 2'd2,
    RESP    = 2'd3
  } wr_state_t;

  // Word index of a byte address: keep the addr_w LSBs, drop the lsb byte-offset bits.
  function automatic logic [31:0] addr_to_index(input logic [31:0] addr,
                                                input int unsigned addr_w,
                                                input int unsigned lsb);
    logic [31:0] w_mask;
    w_mask = (addr_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << addr_w) - 32'd1);
    return (addr & w_mask) >> lsb;
  endfunction

endpackage

// File: rtl/axil_regbank_wchan.sv
// AW/W capture FSM and B channel; presents the commit strobe with the address/data/strobe being written.
//   state   | meaning
//   IDLE    | waiting for AW and W
//   HAVE_AW | address held, waiting for W
//   HAVE_W  | data held, waiting for AW
//   RESP    | write committed, BVALID high until BREADY
module axil_regbank_wchan
  import axil_regbank_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic                    o_commit,
  output logic [ADDR_WIDTH-1:0]   o_addr,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [DATA_WIDTH/8-1:0] o_strb,
  output logic                    o_oor
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);

  wr_state_t             r_state;
  wr_state_t             w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NB-1:0]         r_wstrb;
  logic [1:0]            r_bresp;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic [31:0]           w_idx;

  assign AWREADY = (r_state == IDLE) || (r_state == HAVE_W);
  assign WREADY  = (r_state == IDLE) || (r_state == HAVE_AW);
  assign BVALID  = (r_state == RESP);
  assign BRESP   = r_bresp;

  assign w_aw_hs = AWVALID && AWREADY;
  assign w_w_hs  = WVALID && WREADY;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_aw_hs && w_w_hs) w_state_nxt = RESP;
        else if (w_aw_hs)      w_state_nxt = HAVE_AW;
        else if (w_w_hs)       w_state_nxt = HAVE_W;
      end
      HAVE_AW: if (w_w_hs)  w_state_nxt = RESP;
      HAVE_W:  if (w_aw_hs) w_state_nxt = RESP;
      RESP:    if (BREADY)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The second half of the pair may arrive live on the commit edge, so bypass the capture regs.
  assign o_commit = (r_state != RESP) && (w_state_nxt == RESP);
  assign o_addr   = w_aw_hs ? AWADDR : r_awaddr;
  assign o_data   = w_w_hs ? WDATA : r_wdata;
  assign o_strb   = w_w_hs ? WSTRB : r_wstrb;
  assign w_idx    = addr_to_index(32'(o_addr), ADDR_WIDTH, LSB);
  assign o_oor    = (w_idx >= 32'(NUM_REGS));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state  <= IDLE;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= RESP_OKAY;
    end else begin
      r_state <= w_state_nxt;
      if (w_aw_hs) r_awaddr <= AWADDR;
      if (w_w_hs) begin
        r_wdata <= WDATA;
        r_wstrb <= WSTRB;
      end
      if (o_commit) r_bresp <= o_oor ? RESP_OOR : RESP_OKAY;
    end
  end

endmodule

// File: rtl/axil_regbank.sv
// Parametrised AXI4-Lite register bank: RW/RO register array, read channel and per-register write pulses.
// AXIL_REGBANK_SLVERR_EN (package) makes out-of-range accesses answer SLVERR.
module axil_regbank
  import axil_regbank_pkg::*;
#(
  parameter int                     DATA_WIDTH = 32,
  parameter int                     ADDR_WIDTH = 8,
  parameter int                     NUM_REGS   = 4,
  parameter logic [NUM_REGS-1:0]    RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0]  RESET_VAL  = '0
) (
  input  logic                             ACLK,
  input  logic                             ARESETN,
  input  logic [ADDR_WIDTH-1:0]            AWADDR,
  input  logic [2:0]                       AWPROT,
  input  logic                             AWVALID,
  output logic                             AWREADY,
  input  logic [DATA_WIDTH-1:0]            WDATA,
  input  logic [DATA_WIDTH/8-1:0]          WSTRB,
  input  logic                             WVALID,
  output logic                             WREADY,
  output logic [1:0]                       BRESP,
  output logic                             BVALID,
  input  logic                             BREADY,
  input  logic [ADDR_WIDTH-1:0]            ARADDR,
  input  logic [2:0]                       ARPROT,
  input  logic                             ARVALID,
  output logic                             ARREADY,
  output logic [DATA_WIDTH-1:0]            RDATA,
  output logic [1:0]                       RRESP,
  output logic                             RVALID,
  input  logic                             RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]   reg_i,
  output logic [NUM_REGS-1:0]              wr_pulse_o
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                  w_commit;
  logic                  w_oor;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [NB-1:0]         w_wstrb;
  logic [31:0]           w_widx;
  logic [31:0]           w_ridx;
  logic                  w_r_oor;
  logic                  w_ar_hs;
  logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  // PROT is ignored; reg_i RW slices are unused by construction.
  wire w_unused_ok = ^{AWPROT, ARPROT, reg_i};

  axil_regbank_wchan #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_wchan (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .AWADDR   (AWADDR),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .WDATA    (WDATA),
    .WSTRB    (WSTRB),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .BRESP    (BRESP),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .o_commit (w_commit),
    .o_addr   (w_waddr),
    .o_data   (w_wdata),
    .o_strb   (w_wstrb),
    .o_oor    (w_oor)
  );

  assign w_widx = addr_to_index(32'(w_waddr), ADDR_WIDTH, LSB);

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    if (RO_MASK[k]) begin : g_ro
      assign w_regs[k]                          = reg_i[k*DATA_WIDTH +: DATA_WIDTH];
      assign reg_o[k*DATA_WIDTH +: DATA_WIDTH]  = '0;
      assign wr_pulse_o[k]                      = 1'b0;
    end else begin : g_rw
      logic                  w_sel;
      logic [DATA_WIDTH-1:0] r_val;
      logic                  r_pulse;

      assign w_sel = w_commit && !w_oor && (w_widx == 32'(k));

      always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
          r_val   <= RESET_VAL;
          r_pulse <= 1'b0;
        end else begin
          r_pulse <= w_sel;
          if (w_sel) begin
            for (int b = 0; b < NB; b++) begin
              if (w_wstrb[b]) r_val[b*8 +: 8] <= w_wdata[b*8 +: 8];
            end
          end
        end
      end

      assign w_regs[k]                         = r_val;
      assign reg_o[k*DATA_WIDTH +: DATA_WIDTH] = r_val;
      assign wr_pulse_o[k]                     = r_pulse;
    end
  end

  // w_regs holds pre-commit values, so a read on the commit edge returns the old data.
  assign w_ar_hs = ARVALID && !r_rvalid;
  assign w_ridx  = addr_to_index(32'(ARADDR), ADDR_WIDTH, LSB);
  assign w_r_oor = (w_ridx >= 32'(NUM_REGS));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_r_oor ? '0 : w_regs[w_ridx[IDX_W-1:0]];
      r_rresp  <= w_r_oor ? RESP_OOR : RESP_OKAY;
    end else if (RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  assign ARREADY = !r_rvalid;
  assign RVALID  = r_rvalid;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;

endmodule

// File: tb/tb_axil_regbank.sv
// Self-checking bench for axil_regbank: directed table, corner sequences and randomized traffic vs. a word-array model.
`timescale 1ns/1ps
module tb_axil_regbank;

  localparam int          DW = 32;
  localparam int          AW = 8;
  localparam int          NR = 4;
  localparam logic [3:0]  RO = 4'b1000;
  localparam logic [31:0] RV = 32'h5A5A_0001;
`ifdef AXIL_REGBANK_SLVERR_EN
  localparam logic [1:0]  EXP_OOR = 2'b10;
`else
  localparam logic [1:0]  EXP_OOR = 2'b00;
`endif
  localparam logic [1:0]  OK = 2'b00;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [AW-1:0] AWADDR = '0;
  logic [2:0]    AWPROT = '0;
  logic          AWVALID = 1'b0;
  logic          AWREADY;
  logic [DW-1:0] WDATA = '0;
  logic [3:0]    WSTRB = '0;
  logic          WVALID = 1'b0;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY = 1'b0;
  logic [AW-1:0] ARADDR = '0;
  logic [2:0]    ARPROT = '0;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY = 1'b0;
  logic [NR*DW-1:0] reg_o;
  logic [NR*DW-1:0] reg_i = {32'hCAFE_F00D, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
  logic [NR-1:0]    wr_pulse_o;

  axil_regbank #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_REGS (NR), .RO_MASK (RO), .RESET_VAL (RV)
  ) dut (
    .ACLK (ACLK), .ARESETN (ARESETN),
    .AWADDR (AWADDR), .AWPROT (AWPROT), .AWVALID (AWVALID), .AWREADY (AWREADY),
    .WDATA (WDATA), .WSTRB (WSTRB), .WVALID (WVALID), .WREADY (WREADY),
    .BRESP (BRESP), .BVALID (BVALID), .BREADY (BREADY),
    .ARADDR (ARADDR), .ARPROT (ARPROT), .ARVALID (ARVALID), .ARREADY (ARREADY),
    .RDATA (RDATA), .RRESP (RRESP), .RVALID (RVALID), .RREADY (RREADY),
    .reg_o (reg_o), .reg_i (reg_i), .wr_pulse_o (wr_pulse_o)
  );

  always #5 ACLK = ~ACLK;

  int tests = 0;
  int fails = 0;
  int pulse_cnt [NR] = '{default: 0};
  int exp_pulse [NR] = '{default: 0};
  logic [31:0] mem [NR];
  logic [NR-1:0] ro_mask = RO;

  always @(negedge ACLK)
    for (int k = 0; k < NR; k++) if (wr_pulse_o[k]) pulse_cnt[k]++;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: word index = byte address / 4; RO words read reg_i; out of range reads 0, writes dropped.
  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
    int i;
    i = int'(a) / 4;
    resp = EXP_OOR;
    if (i < NR) begin
      resp = OK;
      if (!ro_mask[i]) begin
        for (int b = 0; b < 4; b++) if (s[b]) mem[i][b*8 +: 8] = d[b*8 +: 8];
        exp_pulse[i]++;
      end
    end
  endtask

  task automatic model_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int i;
    i = int'(a) / 4;
    d = 32'h0;
    resp = EXP_OOR;
    if (i < NR) begin
      resp = OK;
      d = ro_mask[i] ? reg_i[i*32 +: 32] : mem[i];
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NR; k++) mem[k] = RV;
  endtask

  task automatic check_rego(input string nm);
    for (int k = 0; k < NR; k++)
      check($sformatf("%s reg_o[%0d]", nm, k), 128'(reg_o[k*32 +: 32]), 128'(ro_mask[k] ? 32'h0 : mem[k]));
  endtask

  task automatic axi_write_chk(input string nm, input logic [7:0] a, input logic [31:0] d,
                               input logic [3:0] s, input int aw_dly, input int w_dly,
                               input logic [1:0] exp_resp);
    int n;
    bit aw_done, w_done, aw_now, w_now;
    aw_done = 0; w_done = 0; n = 0;
    AWADDR = a; WDATA = d; WSTRB = s;
    while (!(aw_done && w_done) && n < 64) begin
      AWVALID = !aw_done && (n >= aw_dly);
      WVALID  = !w_done && (n >= w_dly);
      aw_now  = AWVALID && AWREADY;
      w_now   = WVALID && WREADY;
      @(posedge ACLK); #1;
      if (aw_now) aw_done = 1;
      if (w_now)  w_done = 1;
      n++;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    check({nm, " aw_w_handshake"}, 128'({aw_done, w_done}), 128'(2'b11));
    n = 0;
    while (!BVALID && n < 64) begin @(posedge ACLK); #1; n++; end
    check({nm, " b_latency"}, 128'(n), 128'(0));
    check({nm, " bresp"}, 128'(BRESP), 128'(exp_resp));
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
  endtask

  task automatic axi_read_chk(input string nm, input logic [7:0] a, input logic [31:0] exp_d,
                              input logic [1:0] exp_resp, input int hold, input bit scramble);
    int n;
    ARADDR = a; ARVALID = 1'b1; n = 0;
    while (!ARREADY && n < 64) begin @(posedge ACLK); #1; n++; end
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    if (scramble) reg_i[127:96] = $urandom();
    n = 0;
    while (!RVALID && n < 64) begin @(posedge ACLK); #1; n++; end
    check({nm, " r_latency"}, 128'(n), 128'(0));
    check({nm, " rdata"}, 128'(RDATA), 128'(exp_d));
    check({nm, " rresp"}, 128'(RRESP), 128'(exp_resp));
    for (int h = 0; h < hold; h++) begin
      @(posedge ACLK); #1;
      check({nm, " r_hold"}, 128'({RVALID, ARREADY, RRESP, RDATA}), 128'({1'b1, 1'b0, exp_resp, exp_d}));
    end
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [7:0]  raddr;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          pulse_reg;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r;
    logic [31:0] ed;
    int          snap [NR];
    logic [15:0] act_d, exp_d;

    vecs[0]  = '{8'h00, 32'h0000_0001, 4'hF, 8'h00, 32'h0000_0001, OK, 0};
    vecs[1]  = '{8'h04, 32'h0000_0002, 4'hF, 8'h04, 32'h0000_0002, OK, 1};
    vecs[2]  = '{8'h08, 32'h0000_0003, 4'hF, 8'h08, 32'h0000_0003, OK, 2};
    vecs[3]  = '{8'h0C, 32'h0000_0004, 4'hF, 8'h0C, 32'hCAFE_F00D, OK, -1};
    vecs[4]  = '{8'h08, 32'h1122_3344, 4'hF, 8'h08, 32'h1122_3344, OK, 2};
    vecs[5]  = '{8'h08, 32'hFFFF_FFFF, 4'h5, 8'h08, 32'h11FF_33FF, OK, 2};
    vecs[6]  = '{8'h00, 32'hFFFF_FFFF, 4'h0, 8'h00, 32'h0000_0001, OK, 0};
    vecs[7]  = '{8'h03, 32'h0000_0077, 4'h1, 8'h02, 32'h0000_0077, OK, 0};
    vecs[8]  = '{8'h40, 32'h0000_0099, 4'hF, 8'h40, 32'h0000_0000, EXP_OOR, -1};
    vecs[9]  = '{8'hFD, 32'h1234_5678, 4'hF, 8'hFC, 32'h0000_0000, EXP_OOR, -1};
    vecs[10] = '{8'h05, 32'hAABB_CCDD, 4'hC, 8'h04, 32'hAABB_0002, OK, 1};

    model_reset();

    // Reset state
    repeat (3) @(posedge ACLK);
    #1;
    check("reset ready/valid", 128'({AWREADY, WREADY, ARREADY, BVALID, RVALID}), 128'(5'b11100));
    check("reset resp/rdata", 128'({BRESP, RRESP, RDATA}), 128'(0));
    check("reset wr_pulse", 128'(wr_pulse_o), 128'(0));
    check_rego("reset");
    @(negedge ACLK) ARESETN = 1'b1;
    @(posedge ACLK); #1;

    // Reset defaults read back
    for (int k = 0; k < NR; k++) begin
      model_read(8'(k * 4), ed, r);
      axi_read_chk($sformatf("default_rd[%0d]", k), 8'(k * 4), ed, r, 0, 0);
    end
    check("default no pulses", 128'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]), 128'(0));

    // Directed table: write then read back
    for (int v = 0; v < 11; v++) begin
      for (int k = 0; k < NR; k++) snap[k] = pulse_cnt[k];
      model_write(vecs[v].waddr, vecs[v].wdata, vecs[v].wstrb, r);
      axi_write_chk($sformatf("vec%0d wr", v), vecs[v].waddr, vecs[v].wdata, vecs[v].wstrb, 0, 0,
                    vecs[v].exp_resp);
      check_rego($sformatf("vec%0d", v));
      axi_read_chk($sformatf("vec%0d rd", v), vecs[v].raddr, vecs[v].exp_rdata, vecs[v].exp_resp, 1, 0);
      for (int k = 0; k < NR; k++) begin
        act_d[k*4 +: 4] = 4'(pulse_cnt[k] - snap[k]);
        exp_d[k*4 +: 4] = (k == vecs[v].pulse_reg) ? 4'd1 : 4'd0;
      end
      check($sformatf("vec%0d pulses", v), 128'(act_d), 128'(exp_d));
    end

    // Decoupled: W first, AW later, B held off by BREADY
    WDATA = 32'hA5A5_A5A5; WSTRB = 4'hF; WVALID = 1'b1;
    check("decoup w_ready", 128'(WREADY), 128'(1));
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    repeat (3) begin
      check("decoup have_w", 128'({AWREADY, WREADY, BVALID}), 128'(3'b100));
      @(posedge ACLK); #1;
    end
    AWADDR = 8'h04; AWVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    model_write(8'h04, 32'hA5A5_A5A5, 4'hF, r);
    check("decoup bvalid", 128'(BVALID), 128'(1));
    check_rego("decoup");
    repeat (5) begin
      @(posedge ACLK); #1;
      check("decoup b_hold", 128'({BVALID, AWREADY, WREADY, BRESP}), 128'({1'b1, 1'b0, 1'b0, OK}));
    end
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    check("decoup b_done", 128'({BVALID, AWREADY, WREADY}), 128'(3'b011));

    // Read and write of the same register on the same edge: read sees old value
    model_read(8'h00, ed, r);
    AWADDR = 8'h00; WDATA = 32'h0F0F_0F0F; WSTRB = 4'hF; ARADDR = 8'h00;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    model_write(8'h00, 32'h0F0F_0F0F, 4'hF, r);
    check("same_edge rdata_old", 128'({RVALID, RDATA}), 128'({1'b1, ed}));
    check("same_edge bvalid", 128'(BVALID), 128'(1));
    check_rego("same_edge");
    BREADY = 1'b1; RREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0; RREADY = 1'b0;
    check("same_edge done", 128'({BVALID, RVALID}), 128'(2'b00));

    // Reset in the middle of a write
    AWADDR = 8'h08; AWVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    check("midrst aw_taken", 128'({AWREADY, WREADY}), 128'(2'b01));
    #2 ARESETN = 1'b0;
    #1;
    model_reset();
    check("midrst flags", 128'({AWREADY, WREADY, ARREADY, BVALID, RVALID}), 128'(5'b11100));
    check_rego("midrst");
    @(negedge ACLK) ARESETN = 1'b1;
    repeat (2) begin
      @(posedge ACLK); #1;
      check("midrst no_b", 128'(BVALID), 128'(0));
    end
    model_write(8'h08, 32'h600D_CAFE, 4'hF, r);
    axi_write_chk("midrst wr", 8'h08, 32'h600D_CAFE, 4'hF, 1, 0, r);
    check_rego("midrst after");
    model_read(8'h08, ed, r);
    axi_read_chk("midrst rd", 8'h08, ed, r, 0, 0);

    // Randomized traffic against the model
    for (int it = 0; it < 300; it++) begin
      logic [7:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom();
        s = 4'($urandom_range(0, 15));
        model_write(a, d, s, r);
        axi_write_chk($sformatf("rand%0d wr", it), a, d, s,
                      $urandom_range(0, 3), $urandom_range(0, 3), r);
        check_rego($sformatf("rand%0d", it));
      end else begin
        if ($urandom_range(0, 3) == 0) reg_i = {$urandom(), $urandom(), $urandom(), $urandom()};
        model_read(a, ed, r);
        axi_read_chk($sformatf("rand%0d rd", it), a, ed, r, $urandom_range(0, 2), 1);
      end
    end

    @(posedge ACLK); #1;
    for (int k = 0; k < NR; k++)
      check($sformatf("pulse_total[%0d]", k), 128'(pulse_cnt[k]), 128'(exp_pulse[k]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
